// File: rtl/seq_subtractor.sv
// Purpose : multi-cycle subtractor, D = a - b, DIGIT bits per clock, with borrow and signed overflow.
// Latency : N = WIDTH/DIGIT cycles from accepted start to the done pulse; one operation per N cycles.
// Backpr. : start is taken only while busy=0 (including the done cycle); start during busy is dropped.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   start, a, b   request and operands, captured when start is accepted
//   busy, done    operation in progress / one-cycle completion pulse
//   D, borrow,ovf result (a-b mod 2^WIDTH), unsigned borrow, signed overflow; held until next done
module seq_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic             borrow_r;
  logic [CW-1:0]    cnt;

  logic [IW-1:0]    base;
  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic [DIGIT:0]   sub;
  logic             last;
  logic             ovf_nxt;

  // Slice datapath: one DIGIT-wide subtract per cycle, borrow chained through borrow_r.
  always_comb begin
    base = IW'(int'(cnt) * DIGIT);
    a_sl = op_a[base +: DIGIT];
    b_sl = op_b[base +: DIGIT];
    // DIGIT+1 bit subtraction: the top bit goes to 1 exactly when the slice result is negative,
    // which is the borrow into the next slice.
    sub  = {1'b0, a_sl} - {1'b0, b_sl} - {{DIGIT{1'b0}}, borrow_r};
    work_nxt = work;
    work_nxt[base +: DIGIT] = sub[DIGIT-1:0];
    last = (cnt == CW'(N - 1));
    // Signed overflow only possible when operand signs differ and the result sign departs from a.
    ovf_nxt = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) & (work_nxt[WIDTH-1] ^ op_a[WIDTH-1]);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = (state == RUN);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, slice stepping and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      work     <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
      D        <= '0;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_a     <= a;
        op_b     <= b;
        work     <= '0;
        borrow_r <= 1'b0;
        cnt      <= '0;
      end else if (state == RUN) begin
        work     <= work_nxt;
        borrow_r <= sub[DIGIT];
        cnt      <= cnt + CW'(1);
        if (last) begin
          // Visible results only move here, so they hold across the following operation.
          D      <= work_nxt;
          borrow <= sub[DIGIT];
          ovf    <= ovf_nxt;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_subtractor.sv
// Purpose : directed and sweep checks of seq_subtractor at DIGIT = 1, 4 and 32.
// Latency : expects done exactly 32, 8 and 1 cycles after the accepting edge.
// Backpr. : exercises start held during busy and start in the done cycle.
module tb_seq_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ai = '0;
  logic [31:0] bi = '0;

  logic        busy1, done1, bor1, ovf1;
  logic        busy4, done4, bor4, ovf4;
  logic        busy32, done32, bor32, ovf32;
  logic [31:0] d1, d4, d32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_subtractor #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .a(ai), .b(bi),
    .busy(busy1), .done(done1), .D(d1), .borrow(bor1), .ovf(ovf1));

  seq_subtractor #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .a(ai), .b(bi),
    .busy(busy4), .done(done4), .D(d4), .borrow(bor4), .ovf(ovf4));

  seq_subtractor #(.WIDTH(32), .DIGIT(32)) u_d32 (
    .clk(clk), .rst(rst), .start(start), .a(ai), .b(bi),
    .busy(busy32), .done(done32), .D(d32), .borrow(bor32), .ovf(ovf32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the DIGIT=4 instance with latency, busy-span and result checks.
  task automatic op4(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] ed, input logic eb, input logic eo);
    int cyc;
    int busycnt;
    ai = av;
    bi = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    busycnt = 0;
    while (!done4 && cyc < 50) begin
      if (busy4) busycnt++;
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 8);
    chk({tag, "_busycnt"}, busycnt, 8);
    chk({tag, "_busy_at_done"}, busy4, 0);
    chk({tag, "_D"}, d4, ed);
    chk({tag, "_borrow"}, bor4, eb);
    chk({tag, "_ovf"}, ovf4, eo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int lat1, lat4, lat32;
    int seen_done;
    logic [31:0] ra, rb, rd;
    logic        rbor, rovf;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_D", d4, 0);
    chk("rst_borrow", bor4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_D32", d32, 0);

    // Basic and borrow-ripple vectors.
    op4("basic",  32'h0000000A, 32'h00000003, 32'h00000007, 1'b0, 1'b0);
    op4("ripple", 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0);
    op4("negov",  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
    op4("posov",  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);

    // Handshake: start held through the run, operands changed mid-run.
    ai = 32'd5;
    bi = 32'd2;
    start = 1'b1;
    tick();
    cyc = 0;
    while (!done4 && cyc < 50) begin
      if (cyc == 3) begin
        ai = 32'd9;
        bi = 32'd9;
      end
      tick();
      cyc++;
    end
    chk("hs1_lat", cyc, 8);
    chk("hs1_D", d4, 32'd3);
    chk("hs1_borrow", bor4, 0);
    // start is still high in the done cycle, so the 9-9 request goes in here.
    tick();
    start = 1'b0;
    chk("hs2_accepted", busy4, 1);
    cyc = 0;
    while (!done4 && cyc < 50) begin
      chk($sformatf("hs_hold_%0d", cyc), d4, 32'd3);
      tick();
      cyc++;
    end
    chk("hs2_lat", cyc, 8);
    chk("hs2_D", d4, 32'd0);
    chk("hs2_borrow", bor4, 0);

    // Reset during an operation.
    ai = 32'h12345678;
    bi = 32'h1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", busy4, 0);
    chk("rstmid_D", d4, 0);
    chk("rstmid_borrow", bor4, 0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done4) seen_done = 1;
      tick();
    end
    chk("rstmid_no_done", seen_done, 0);
    op4("after_rst", 32'h12345678, 32'h00000001, 32'h12345677, 1'b0, 1'b0);

    // Sweep all three digit widths together against a whole-word reference.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      case (k)
        0: begin ra = 32'h0;        rb = 32'h0;        end
        1: begin ra = 32'hFFFFFFFF; rb = 32'h0;        end
        2: begin ra = 32'h0;        rb = 32'hFFFFFFFF; end
        3: begin ra = 32'h80000000; rb = 32'h80000000; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      {rbor, rd} = {1'b0, ra} - {1'b0, rb};
      rovf = (ra[31] ^ rb[31]) & (rd[31] ^ ra[31]);
      ai = ra;
      bi = rb;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat1 = 0;
      lat4 = 0;
      lat32 = 0;
      for (int c = 1; c <= 40 && lat1 == 0; c++) begin
        tick();
        if (done1 && lat1 == 0) lat1 = c;
        if (done4 && lat4 == 0) lat4 = c;
        if (done32 && lat32 == 0) lat32 = c;
      end
      chk($sformatf("sw%0d_lat1", k), lat1, 32);
      chk($sformatf("sw%0d_lat4", k), lat4, 8);
      chk($sformatf("sw%0d_lat32", k), lat32, 1);
      chk($sformatf("sw%0d_D1", k), d1, rd);
      chk($sformatf("sw%0d_D4", k), d4, rd);
      chk($sformatf("sw%0d_D32", k), d32, rd);
      chk($sformatf("sw%0d_b1", k), bor1, rbor);
      chk($sformatf("sw%0d_b4", k), bor4, rbor);
      chk($sformatf("sw%0d_b32", k), bor32, rbor);
      chk($sformatf("sw%0d_o1", k), ovf1, rovf);
      chk($sformatf("sw%0d_o4", k), ovf4, rovf);
      chk($sformatf("sw%0d_o32", k), ovf32, rovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_subtractor.md
# seq_subtractor

Multi-cycle unsigned/two's-complement subtractor computing D = a − b with a borrow out. It processes DIGIT bits per clock under a start/done handshake. It is the inverse-operation companion to the team's 32-bit ripple-carry adder: same operand width and same output split (WIDTH-bit result plus one extra flag bit). It sits in the arithmetic datapath, where area matters more than single-cycle latency.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- DIGIT, 4, bits processed per clock. Must divide WIDTH; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; D/borrow/ovf valid from this cycle on.
- D  output  WIDTH  (a − b) mod 2^WIDTH.
- borrow  output  1  1 iff a < b (unsigned).
- ovf  output  1  signed overflow: a[WIDTH-1]≠b[WIDTH-1] and D[WIDTH-1]≠a[WIDTH-1].

## Operation
- Two states: IDLE and RUN. Internal registers:
  - op_a and op_b (WIDTH each)
  - work result register (WIDTH)
  - borrow_r
  - slice counter (ceil(log2 N)+1 bits)
- IDLE with start=1 accepted:
  - latch op_a←a, op_b←b.
  - clear borrow_r and counter.
  - go to RUN; busy=1.
- RUN, each cycle, slice i = counter, covering bits [i·DIGIT +: DIGIT]:
  - compute {bout, diff} = op_a_slice − op_b_slice − borrow_r, as a DIGIT+1-bit subtraction.
  - write diff into the work slice; borrow_r←bout; counter+1.
- Last slice (i = N−1):
  - D←final work value, borrow←bout, ovf per the formula above.
  - done=1 for exactly one cycle.
  - state→IDLE, busy=0.
- D, borrow and ovf change only at completion. They hold their value until the next completion or rst.
- start while busy=1 is ignored. It is neither queued nor latched, and changes to a/b during RUN have no effect.
- start asserted in the done cycle (busy=0) is accepted, giving back-to-back operations with no idle gap.
- DIGIT=WIDTH degenerates to N=1: result appears one cycle after start.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, D=0, borrow=0, ovf=0.
  - counter=0, borrow_r=0.
- Latency:
  - start sampled high at edge E0 → busy=1 after E0.
  - slices processed at edges E1..EN.
  - done=1 and outputs valid after EN, i.e. N clock cycles after acceptance.
- Throughput: one operation per N cycles.
- busy and done are never both 1.
- Reset mid-operation: at the rst edge, the operation is aborted and all outputs and state take their reset values. No done is issued for the aborted op.
- rst dominates start in the same cycle.
- Unsigned wrap-around: a<b yields D=2^WIDTH−(b−a), borrow=1.

## Test plan
Defaults WIDTH=32, DIGIT=4 unless noted.
- Basic: a=0x0000000A, b=0x00000003, start 1 cycle → done exactly 8 cycles after the start edge; D=0x00000007, borrow=0, ovf=0; busy high for those 8 cycles.
- Full borrow ripple: a=0x00000000, b=0x00000001 → D=0xFFFFFFFF, borrow=1, ovf=0. Then a=0x80000000, b=0x00000001 → D=0x7FFFFFFF, borrow=0, ovf=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF → D=0x80000000, borrow=1, ovf=1.
- Handshake: start a=5, b=2. Hold start high and change a=9, b=9 at cycle 3 → first result D=3, unaffected. Start a=9, b=9 in the done cycle → accepted; second done 8 cycles later with D=0, borrow=0. D holds 3 between the two dones.
- Reset mid-op: start a=0x12345678, b=0x1, assert rst at cycle 4 → busy=0, D=0, no done pulse. Next op a=0x12345678, b=0x1 → D=0x12345677 after 8 cycles.
- Parameter sweep: DIGIT ∈ {1, 4, 32}, 1000 random operand pairs each → D, borrow and ovf match a reference model of a−b. Latency = 32, 8 and 1 cycles respectively.
